// File: rtl/stage_fetch.sv
// stage_fetch: sequential instruction fetch with a small return-word FIFO and
// wrong-path squashing on redirect. Define FETCH_PERF_EN to add perf counters.
module stage_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        discard,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic        instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

  // Handshakes: a fetch transfers on a cycle where mem_req & mem_gnt; mem_req
  // and mem_addr stay stable until then unless redirect intervenes. A word
  // leaves the FIFO on a cycle where instr_valid & (~stall | discard).
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_n;
  logic [CW-1:0] kill;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_word [FIFO_DEPTH];
  logic [31:0]   pcq       [FIFO_DEPTH];
  logic [CW:0]   inflight;
  logic          grant;
  logic          resp_kill;
  logic          push;
  logic          pop;
  logic          discard_pop;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Credit counts every granted-but-unreturned fetch, killed ones included,
  // so the FIFO and the in-flight PC queue can never overflow.
  assign inflight = {1'b0, outstanding} + {1'b0, count};
  assign mem_req  = ~rst & ~redirect & (inflight < DEPTH_W);
  assign mem_addr = fetch_pc;
  assign grant    = mem_req & mem_gnt;

  assign resp_kill   = mem_rvalid & (kill != '0);
  assign push        = mem_rvalid & ~redirect & (kill == '0);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & (~stall | discard) & ~redirect;
  assign discard_pop = pop & discard;

  assign pc_out = fifo_pc[rd_ptr];
  assign instr  = fifo_word[rd_ptr];

  always_comb begin
    outstanding_n = outstanding;
    if (grant & ~mem_rvalid) begin
      outstanding_n = outstanding + 1'b1;
    end else if (~grant & mem_rvalid) begin
      outstanding_n = outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
        pcq[i]       <= '0;
      end
    end else begin
      outstanding <= outstanding_n;
      if (grant) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + 1'b1;
      end
      if (mem_rvalid) begin
        pcq_rd <= pcq_rd + 1'b1;
      end
      if (redirect) begin
        // Everything still in flight returns on the old path and must be dropped.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        kill     <= outstanding - CW'(mem_rvalid);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp_kill) begin
          kill <= kill - 1'b1;
        end
        if (push) begin
          fifo_pc[wr_ptr]   <= pcq[pcq_rd];
          fifo_word[wr_ptr] <= mem_rdata;
          wr_ptr            <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] squash_inc;

  // A redirect squashes the buffered words plus any untagged response it drops.
  always_comb begin
    squash_inc = 32'(resp_kill) + 32'(discard_pop);
    if (redirect) begin
      squash_inc = squash_inc + 32'(count) + 32'(mem_rvalid & (kill == '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(push);
      perf_squashed <= perf_squashed + squash_inc;
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: memory responder model, sequential-PC
// scoreboard and hand-computed cycle checks.
module tb_stage_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        discard = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_resp = 0;
  int          n_used = 0;
  logic        resp_hold = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] mem_q[$];

  stage_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .discard(discard),
    .pc_out(pc_out), .instr(instr), .instr_valid(instr_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Called at a negedge: scoreboard, bounds, then the clock edge and memory.
  task automatic finish_cycle();
    logic        fire;
    logic [31:0] faddr;
    logic [31:0] a;
    chk("fifo_bound", 32'(dut.count <= 2), 32'd1);
    chk("outstanding_bound", 32'(mem_q.size() <= 2), 32'd1);
    if (instr_valid && !redirect) begin
      if (discard) begin
        exp_pc = exp_pc + 32'd4;
      end else if (!stall) begin
        chk("sb_pc", pc_out, exp_pc);
        chk("sb_instr", instr, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_used++;
      end
    end
    if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    fire  = mem_req & mem_gnt;
    faddr = mem_addr;
    @(posedge clk);
    #1;
    if (fire) mem_q.push_back(faddr);
    if (!resp_hold && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = word_of(a);
      n_resp++;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_q.delete();
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    mem_gnt = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    discard = 1'b0;
    resp_hold = 1'b0;
    n_resp = 0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr", instr, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 32'h0000_0000;
  endtask

  initial begin
    // Sequential fetch from reset with 1-cycle memory
    do_reset();
    @(negedge clk); chk("t1_req_c0", 32'(mem_req), 32'd1); chk("t1_addr_c0", mem_addr, 32'h0);
    chk("t1_valid_c0", 32'(instr_valid), 32'd0); finish_cycle();
    @(negedge clk); chk("t1_addr_c1", mem_addr, 32'h4); chk("t1_valid_c1", 32'(instr_valid), 32'd0);
    finish_cycle();
    @(negedge clk); chk("t1_valid_c2", 32'(instr_valid), 32'd1); chk("t1_pc_c2", pc_out, 32'h0);
    chk("t1_req_c2", 32'(mem_req), 32'd0); finish_cycle();
    @(negedge clk); chk("t1_addr_c3", mem_addr, 32'h8); chk("t1_pc_c3", pc_out, 32'h4);
    finish_cycle();
    repeat (8) cycle();
    chk("t1_words_used", 32'(n_used >= 6), 32'd1);

    // Stall holds the FIFO full and throttles requests
    stall = 1'b1;
    repeat (5) cycle();
    @(negedge clk); chk("t2_req_full", 32'(mem_req), 32'd0); chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_head", pc_out, exp_pc); finish_cycle();
    stall = 1'b0;
    repeat (6) cycle();

    // Redirect with two fetches outstanding
    resp_hold = 1'b1;
    repeat (4) cycle();
    @(negedge clk); chk("t3_req_credit", 32'(mem_req), 32'd0); chk("t3_valid_empty", 32'(instr_valid), 32'd0);
    finish_cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_1003; resp_hold = 1'b0;
    @(negedge clk); chk("t3_req_redir", 32'(mem_req), 32'd0); finish_cycle();
    redirect = 1'b0;
    @(negedge clk); chk("t3_req_r1", 32'(mem_req), 32'd0); chk("t3_valid_r1", 32'(instr_valid), 32'd0);
    finish_cycle();
    @(negedge clk); chk("t3_req_r2", 32'(mem_req), 32'd1); chk("t3_addr_r2", mem_addr, 32'h0000_1000);
    chk("t3_valid_r2", 32'(instr_valid), 32'd0); finish_cycle();
    @(negedge clk); chk("t3_addr_r3", mem_addr, 32'h0000_1004); chk("t3_valid_r3", 32'(instr_valid), 32'd0);
    finish_cycle();
    @(negedge clk); chk("t3_valid_r4", 32'(instr_valid), 32'd1); chk("t3_pc_r4", pc_out, 32'h0000_1000);
    chk("t3_instr_r4", instr, word_of(32'h0000_1000));
`ifdef FETCH_PERF_EN
    chk("t3_perf_squashed", perf_squashed, 32'd2);
`endif
    finish_cycle();
    repeat (4) cycle();

    // Discard two buffered words, then redirect
    stall = 1'b1;
    repeat (5) cycle();
    @(negedge clk); chk("t4_valid_full", 32'(instr_valid), 32'd1); chk("t4_req_full", 32'(mem_req), 32'd0);
    finish_cycle();
    discard = 1'b1;
    repeat (2) cycle();
    discard = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2000;
    @(negedge clk); chk("t4_valid_after_discard", 32'(instr_valid), 32'd0); finish_cycle();
    redirect = 1'b0;
    @(negedge clk); chk("t4_req_d4", 32'(mem_req), 32'd1); chk("t4_addr_d4", mem_addr, 32'h0000_2000);
    finish_cycle();
    @(negedge clk); chk("t4_addr_d5", mem_addr, 32'h0000_2004); finish_cycle();
    @(negedge clk); chk("t4_valid_d6", 32'(instr_valid), 32'd1); chk("t4_pc_d6", pc_out, 32'h0000_2000);
    finish_cycle();
    repeat (4) cycle();
`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("t4_perf_fetched", perf_fetched, 32'(n_resp - 3 - int'(mem_rvalid)));
    finish_cycle();
`endif

    // Grant withheld for three cycles (also a mid-operation reset)
    do_reset();
    cycle();
    cycle();
    @(negedge clk); chk("t5_req_c2", 32'(mem_req), 32'd0); finish_cycle();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t5_req_hold", 32'(mem_req), 32'd1); chk("t5_addr_hold", mem_addr, 32'h8);
      finish_cycle();
    end
    mem_gnt = 1'b1;
    @(negedge clk); chk("t5_addr_gnt", mem_addr, 32'h8); finish_cycle();
    @(negedge clk); chk("t5_addr_next", mem_addr, 32'hC); chk("t5_req_next", 32'(mem_req), 32'd1);
    finish_cycle();
    repeat (4) cycle();

    // Address wrap at the top of the space
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk); chk("t6_req_redir", 32'(mem_req), 32'd0); finish_cycle();
    redirect = 1'b0;
    @(negedge clk); chk("t6_addr_top", mem_addr, 32'hFFFF_FFFC); chk("t6_req_top", 32'(mem_req), 32'd1);
    finish_cycle();
    @(negedge clk); chk("t6_addr_wrap", mem_addr, 32'h0); chk("t6_req_wrap", 32'(mem_req), 32'd1);
    finish_cycle();
    @(negedge clk); chk("t6_pc_top", pc_out, 32'hFFFF_FFFC); chk("t6_valid_top", 32'(instr_valid), 32'd1);
    finish_cycle();
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
